addr_mar_gen: RTL
=================

# addr_mar_gen

Parametrised memory address register with built-in read and write pointer generators for the image down-sampling datapath. It sits between the accumulator, the sequencer and DRAM. It holds the current DRAM address. It also maintains a source-image read pointer that strides by the decimation factor and a destination-image write pointer that steps by one. The sequencer steps each pointer with a single strobe instead of loading row/column registers explicitly.

## Interface
Parameters:
- ROW_W, 8: row field width in bits.
- COL_W, 8: column field width in bits.
- ADDR_W, ROW_W+COL_W: address width. Derived; never overridden.
- SRC_ROWS, 256: source image rows. Must be ≤ 2^ROW_W and divisible by STEP.
- SRC_COLS, 256: source image columns. Must be ≤ 2^COL_W and divisible by STEP.
- STEP, 2: decimation factor. Must be a power of two, ≥ 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ac_in  in  ADDR_W  address from the accumulator.
- mar_sel  in  2  MAR source select: 00 hold, 01 ac_in, 10 read pointer, 11 write pointer.
- init  in  1  clears both pointers and both done flags.
- rd_step  in  1  advances the read pointer by one decimated pixel.
- wr_step  in  1  advances the write pointer by one pixel.
- mar_out  out  ADDR_W  registered DRAM address.
- rd_row, rd_col  out  ROW_W, COL_W  current read pointer.
- wr_row, wr_col  out  ROW_W, COL_W  current write pointer.
- rd_done  out  1  source traversal complete.
- wr_done  out  1  destination traversal complete.

## Operation
- Reset (resetn=0 at a clock edge): mar_out, rd_row, rd_col, wr_row, wr_col, rd_done and wr_done are all 0. Reset overrides every other input.
- MAR load per mar_sel:
  - 01 loads ac_in.
  - 10 loads {rd_row, rd_col}.
  - 11 loads {wr_row, wr_col}.
  - 00 holds.
  - Pointer values are the registered (pre-step) values of the same cycle.
- Read pointer, on rd_step=1 with rd_done=0:
  - If rd_col+STEP < SRC_COLS: rd_col += STEP.
  - Else if rd_row+STEP < SRC_ROWS: rd_col = 0, rd_row += STEP.
  - Else: pointer holds and rd_done is set.
- Write pointer, on wr_step=1 with wr_done=0: same rule using limits SRC_COLS/STEP and SRC_ROWS/STEP and increment 1. On the last pixel wr_done is set and the pointer holds.
- Steps are ignored while the corresponding done flag is 1.
- Comparisons are done at ROW_W+1 / COL_W+1 bits so that a limit of 2^W never overflows.
- init=1 clears both pointers and both done flags. It takes priority over rd_step and wr_step in the same cycle. The MAR load still occurs, using the pre-init values.
- rd_step and wr_step are independent and may be asserted in the same cycle.

## Timing
- mar_out latency: 1 cycle after mar_sel is sampled.
- Pointer outputs: updated 1 cycle after the step strobe.
- Done flags: assert on the edge that consumes the final step. They stay high until init or reset.
- Step and load in the same cycle: MAR captures the old pointer value, then the pointer advances. This supports a back-to-back load-and-step sequence at one pixel per cycle.
- No handshake back-pressure. Stepping while done is a silent no-op.
- Reset asserted mid-traversal: every output returns to 0 on that edge. Stepping resumes from (0,0) once resetn returns to 1.

## Test plan
Use SRC_ROWS=4, SRC_COLS=8, STEP=2 unless stated.

- Reset: hold resetn=0 for 2 cycles with all strobes high -> every output is 0. Release -> first rd_step gives rd_row=0, rd_col=2.
- Read sweep: 8 consecutive rd_step with mar_sel=10 -> mar_out sequence (row,col) = (0,0),(0,2),(0,4),(0,6),(2,0),(2,2),(2,4),(2,6). rd_done=1 after the 8th step. A 9th step -> pointer stays at (2,6).
- Write sweep: 8 wr_step -> (0,0)…(0,3),(1,0)…(1,3). wr_done=1 after the 8th step.
- Simultaneous events:
  - rd_step, wr_step and mar_sel=11 in one cycle -> mar_out = old write pointer, and both pointers advance.
  - init and rd_step together -> rd pointer = (0,0), rd_done=0.
- AC load: ac_in=16'hA55A, mar_sel=01 -> mar_out=16'hA55A next cycle. It holds with mar_sel=00 across 5 cycles.
- Default parameters 256×256, STEP=2: 16384 rd_step -> last pointer (254,254) and rd_done=1. 16384 wr_step -> last pointer (127,127) and wr_done=1, with no wrap past 255.

Source files
------------

// File: rtl/addr_mar_gen.sv
// Memory address register for the down-sampling datapath, with a decimating
// source read pointer and a unit-stride destination write pointer.
module addr_mar_gen #(
    parameter int unsigned ROW_W    = 8,
    parameter int unsigned COL_W    = 8,
    parameter int unsigned ADDR_W   = ROW_W + COL_W,
    parameter int unsigned SRC_ROWS = 256,
    parameter int unsigned SRC_COLS = 256,
    parameter int unsigned STEP     = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] ac_in,
    input  logic [1:0]        mar_sel,
    input  logic              init,
    input  logic              rd_step,
    input  logic              wr_step,
    output logic [ADDR_W-1:0] mar_out,
    output logic [ROW_W-1:0]  rd_row,
    output logic [COL_W-1:0]  rd_col,
    output logic [ROW_W-1:0]  wr_row,
    output logic [COL_W-1:0]  wr_col,
    output logic              rd_done,
    output logic              wr_done
);

    // One extra bit on every compare so a limit of 2^W is representable.
    localparam int unsigned ROW_CW = ROW_W + 1;
    localparam int unsigned COL_CW = COL_W + 1;

    localparam logic [ROW_W:0] RD_ROW_LIM = ROW_CW'(SRC_ROWS);
    localparam logic [COL_W:0] RD_COL_LIM = COL_CW'(SRC_COLS);
    localparam logic [ROW_W:0] RD_ROW_INC = ROW_CW'(STEP);
    localparam logic [COL_W:0] RD_COL_INC = COL_CW'(STEP);

    localparam logic [ROW_W:0] WR_ROW_LIM = ROW_CW'(SRC_ROWS / STEP);
    localparam logic [COL_W:0] WR_COL_LIM = COL_CW'(SRC_COLS / STEP);
    localparam logic [ROW_W:0] WR_ROW_INC = ROW_CW'(1);
    localparam logic [COL_W:0] WR_COL_INC = COL_CW'(1);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_AC   = 2'b01;
    localparam logic [1:0] SEL_RD   = 2'b10;
    localparam logic [1:0] SEL_WR   = 2'b11;

    logic [ROW_W:0]      rd_row_inc_c;
    logic [COL_W:0]      rd_col_inc_c;
    logic [ROW_W:0]      wr_row_inc_c;
    logic [COL_W:0]      wr_col_inc_c;

    logic [ADDR_W-1:0]   mar_nxt_c;
    logic [ROW_W-1:0]    rd_row_nxt_c;
    logic [COL_W-1:0]    rd_col_nxt_c;
    logic                rd_done_nxt_c;
    logic [ROW_W-1:0]    wr_row_nxt_c;
    logic [COL_W-1:0]    wr_col_nxt_c;
    logic                wr_done_nxt_c;

    assign rd_row_inc_c = {1'b0, rd_row} + RD_ROW_INC;
    assign rd_col_inc_c = {1'b0, rd_col} + RD_COL_INC;
    assign wr_row_inc_c = {1'b0, wr_row} + WR_ROW_INC;
    assign wr_col_inc_c = {1'b0, wr_col} + WR_COL_INC;

    // MAR source mux; pointer selections see the pre-step register values.
    always_comb begin
        mar_nxt_c = mar_out;
        case (mar_sel)
            SEL_HOLD: mar_nxt_c = mar_out;
            SEL_AC:   mar_nxt_c = ac_in;
            SEL_RD:   mar_nxt_c = {rd_row, rd_col};
            SEL_WR:   mar_nxt_c = {wr_row, wr_col};
            default:  mar_nxt_c = mar_out;
        endcase
    end

    // Read pointer: raster walk over the source image in STEP strides.
    always_comb begin
        rd_row_nxt_c  = rd_row;
        rd_col_nxt_c  = rd_col;
        rd_done_nxt_c = rd_done;
        if (init) begin
            rd_row_nxt_c  = '0;
            rd_col_nxt_c  = '0;
            rd_done_nxt_c = 1'b0;
        end else if (rd_step && !rd_done) begin
            if (rd_col_inc_c < RD_COL_LIM) begin
                rd_col_nxt_c = rd_col_inc_c[COL_W-1:0];
            end else if (rd_row_inc_c < RD_ROW_LIM) begin
                rd_col_nxt_c = '0;
                rd_row_nxt_c = rd_row_inc_c[ROW_W-1:0];
            end else begin
                rd_done_nxt_c = 1'b1;
            end
        end
    end

    // Write pointer: raster walk over the decimated destination image.
    always_comb begin
        wr_row_nxt_c  = wr_row;
        wr_col_nxt_c  = wr_col;
        wr_done_nxt_c = wr_done;
        if (init) begin
            wr_row_nxt_c  = '0;
            wr_col_nxt_c  = '0;
            wr_done_nxt_c = 1'b0;
        end else if (wr_step && !wr_done) begin
            if (wr_col_inc_c < WR_COL_LIM) begin
                wr_col_nxt_c = wr_col_inc_c[COL_W-1:0];
            end else if (wr_row_inc_c < WR_ROW_LIM) begin
                wr_col_nxt_c = '0;
                wr_row_nxt_c = wr_row_inc_c[ROW_W-1:0];
            end else begin
                wr_done_nxt_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mar_out <= '0;
            rd_row  <= '0;
            rd_col  <= '0;
            rd_done <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_done <= 1'b0;
        end else begin
            mar_out <= mar_nxt_c;
            rd_row  <= rd_row_nxt_c;
            rd_col  <= rd_col_nxt_c;
            rd_done <= rd_done_nxt_c;
            wr_row  <= wr_row_nxt_c;
            wr_col  <= wr_col_nxt_c;
            wr_done <= wr_done_nxt_c;
        end
    end

endmodule
